// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a raw byte stream with preamble/SFD, zero-pads to
// the minimum frame length, appends the reflected CRC-32 FCS and enforces the inter-frame gap.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       RGMII_RX_CLK,
    input  logic       RESET_N,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    input  logic       S_LAST,
    output logic       S_READY,
    output logic [7:0] TX_DATA,
    output logic       TX_DV,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       UNDERRUN
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam int          PRE_LAST_I = (PREAMBLE_LEN > 1) ? PREAMBLE_LEN - 1 : 0;
    localparam int          IFG_LAST_I = (IFG_CYCLES > 1) ? IFG_CYCLES - 1 : 0;
    localparam logic [15:0] PRE_LAST   = PRE_LAST_I[15:0];
    localparam logic [15:0] IFG_LAST   = IFG_LAST_I[15:0];
    localparam logic [31:0] MIN_LEN    = MIN_FRAME;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_dv_q, tx_dv_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cyc_q, cyc_d;
    logic        done_q, done_d;
    logic        urun_q, urun_d;
    logic [15:0] cnt_inc;
    logic [31:0] fcs_sh;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign S_READY    = (state_q == ST_SFD) || (state_q == ST_PAYLOAD);
    assign BUSY       = (state_q != ST_IDLE);
    assign TX_DATA    = tx_data_q;
    assign TX_DV      = tx_dv_q;
    assign FRAME_DONE = done_q;
    assign UNDERRUN   = urun_q;

    always_comb begin
        state_d   = state_q;
        tx_data_d = 8'h00;
        tx_dv_d   = 1'b0;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        cyc_d     = cyc_q;
        done_d    = 1'b0;
        urun_d    = 1'b0;
        cnt_inc   = sat_inc(cnt_q);
        fcs_sh    = (~crc_q) >> {cyc_q[1:0], 3'b000};

        case (state_q)
            ST_IDLE: begin
                if (S_VALID) begin
                    state_d   = ST_PREAMBLE;
                    tx_data_d = 8'h55;
                    tx_dv_d   = 1'b1;
                    cnt_d     = 16'd0;
                    crc_d     = CRC_INIT;
                    cyc_d     = 16'd0;
                end
            end
            ST_PREAMBLE: begin
                tx_dv_d = 1'b1;
                if (cyc_q >= PRE_LAST) begin
                    state_d   = ST_SFD;
                    tx_data_d = 8'hD5;
                end else begin
                    tx_data_d = 8'h55;
                    cyc_d     = cyc_q + 16'd1;
                end
            end
            ST_SFD, ST_PAYLOAD: begin
                if (S_VALID) begin
                    tx_dv_d   = 1'b1;
                    tx_data_d = S_DATA;
                    cnt_d     = cnt_inc;
                    crc_d     = crc_byte(crc_q, S_DATA);
                    if (S_LAST) begin
                        cyc_d   = 16'd0;
                        state_d = ({16'd0, cnt_inc} < MIN_LEN) ? ST_PAD : ST_FCS;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    // Source starved mid-frame: abandon it without an FCS.
                    urun_d  = 1'b1;
                    cyc_d   = 16'd0;
                    state_d = ST_IFG;
                end
            end
            ST_PAD: begin
                tx_dv_d = 1'b1;
                cnt_d   = cnt_inc;
                crc_d   = crc_byte(crc_q, 8'h00);
                if ({16'd0, cnt_inc} >= MIN_LEN) begin
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                tx_dv_d   = 1'b1;
                tx_data_d = fcs_sh[7:0];
                if (cyc_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    cyc_d   = 16'd0;
                    state_d = ST_IFG;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ST_IFG: begin
                if (cyc_q >= IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge RGMII_RX_CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            tx_data_q <= 8'h00;
            tx_dv_q   <= 1'b0;
            cnt_q     <= 16'd0;
            crc_q     <= CRC_INIT;
            cyc_q     <= 16'd0;
            done_q    <= 1'b0;
            urun_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_dv_q   <= tx_dv_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
            urun_q    <= urun_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: one padding instance (MIN_FRAME=60) and one
// unpadded instance (MIN_FRAME=0), selected by sel.
module tb_eth_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       sel;

    logic       va, vb;
    logic       rdy_a, dv_a, busy_a, done_a, urun_a;
    logic       rdy_b, dv_b, busy_b, done_b, urun_b;
    logic [7:0] data_a, data_b;
    logic       m_rdy, m_dv, m_busy, m_done, m_urun;
    logic [7:0] m_data;

    always #4 clk = ~clk;

    assign va     = s_valid & ~sel;
    assign vb     = s_valid & sel;
    assign m_rdy  = sel ? rdy_b  : rdy_a;
    assign m_dv   = sel ? dv_b   : dv_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_urun = sel ? urun_b : urun_a;
    assign m_data = sel ? data_b : data_a;

    eth_tx_framer dut_a (
        .RGMII_RX_CLK(clk), .RESET_N(rst_n), .S_DATA(s_data), .S_VALID(va), .S_LAST(s_last),
        .S_READY(rdy_a), .TX_DATA(data_a), .TX_DV(dv_a), .BUSY(busy_a),
        .FRAME_DONE(done_a), .UNDERRUN(urun_a)
    );

    eth_tx_framer #(.MIN_FRAME(0)) dut_b (
        .RGMII_RX_CLK(clk), .RESET_N(rst_n), .S_DATA(s_data), .S_VALID(vb), .S_LAST(s_last),
        .S_READY(rdy_b), .TX_DATA(data_b), .TX_DV(dv_b), .BUSY(busy_b),
        .FRAME_DONE(done_b), .UNDERRUN(urun_b)
    );

    logic [7:0] expq[$];
    logic [7:0] exp_b;
    int  cyc = 0, checks = 0, failures = 0;
    int  dv_cnt = 0, done_cnt = 0, urun_cnt = 0;
    int  low_run = 0, last_gap = -1, first_rise = -1;
    bit  prev_dv = 1'b0, hs = 1'b0;

    function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_preamble();
        for (int i = 0; i < 7; i++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
    endtask

    task automatic push_frame(input logic [7:0] d[$], input int min_len);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        body = d;
        while (body.size() < min_len) body.push_back(8'h00);
        push_preamble();
        foreach (body[i]) expq.push_back(body[i]);
        fcs = crc_ref(body);
        for (int i = 0; i < 4; i++) expq.push_back(fcs[8*i +: 8]);
    endtask

    // One clock: monitor the selected instance on the falling edge, then advance.
    task automatic tick();
        @(negedge clk);
        hs = m_rdy && s_valid;
        if (m_dv) begin
            dv_cnt++;
            if (!prev_dv) begin
                last_gap = low_run;
                if (first_rise < 0) first_rise = cyc;
            end
            low_run = 0;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL tx_byte: got %02h at cycle %0d, scoreboard empty", m_data, cyc);
            end else begin
                exp_b = expq.pop_front();
                if (m_data !== exp_b) begin
                    failures++;
                    $display("FAIL tx_byte: got %02h, expected %02h at cycle %0d", m_data, exp_b, cyc);
                end
            end
        end else begin
            low_run++;
            checks++;
            if (m_data !== 8'h00) begin
                failures++;
                $display("FAIL idle_data: TX_DATA=%02h while TX_DV=0, expected 00", m_data);
            end
        end
        if (m_done) done_cnt++;
        if (m_urun) begin
            urun_cnt++;
            checks++;
            if (m_dv !== 1'b0 || prev_dv !== 1'b1) begin
                failures++;
                $display("FAIL urun_align: TX_DV=%0b prev=%0b, expected 0 after 1", m_dv, prev_dv);
            end
        end
        prev_dv = m_dv;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [7:0] d[$], input bit with_last);
        int i = 0;
        int guard = 0;
        while (i < d.size() && guard < 3000) begin
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = with_last && (i == d.size() - 1);
            tick();
            guard++;
            if (hs) i++;
        end
        s_last = 1'b0;
        checks++;
        if (i < d.size()) begin
            failures++;
            $display("FAIL drive_timeout: accepted %0d of %0d bytes", i, d.size());
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: BUSY=%0b after %0d cycles, expected 0", m_busy, n);
        end
        tick();
    endtask

    task automatic check_frame(input string name, input int dv0, input int dvexp,
                               input int f0, input int fexp, input int u0, input int uexp);
        checks += 4;
        if (dv_cnt - dv0 != dvexp) begin
            failures++;
            $display("FAIL %s_dv_cycles: got %0d, expected %0d", name, dv_cnt - dv0, dvexp);
        end
        if (done_cnt - f0 != fexp) begin
            failures++;
            $display("FAIL %s_frame_done: got %0d pulses, expected %0d", name, done_cnt - f0, fexp);
        end
        if (urun_cnt - u0 != uexp) begin
            failures++;
            $display("FAIL %s_underrun: got %0d pulses, expected %0d", name, urun_cnt - u0, uexp);
        end
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d expected bytes never sent, expected 0", name, expq.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks += 6;
        if (dv_a !== 1'b0)     begin failures++; $display("FAIL %s_tx_dv: got %0b, expected 0", name, dv_a); end
        if (data_a !== 8'h00)  begin failures++; $display("FAIL %s_tx_data: got %02h, expected 00", name, data_a); end
        if (rdy_a !== 1'b0)    begin failures++; $display("FAIL %s_s_ready: got %0b, expected 0", name, rdy_a); end
        if (busy_a !== 1'b0)   begin failures++; $display("FAIL %s_busy: got %0b, expected 0", name, busy_a); end
        if (done_a !== 1'b0)   begin failures++; $display("FAIL %s_frame_done: got %0b, expected 0", name, done_a); end
        if (urun_a !== 1'b0)   begin failures++; $display("FAIL %s_underrun: got %0b, expected 0", name, urun_a); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        checks++;
        if (dv_b !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: TX_DV=%0b BUSY=%0b, expected 0 0", dv_b, busy_b);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_padding();
        logic [7:0] d[$];
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        sel = 1'b0;
        for (int i = 0; i < 14; i++) d.push_back(8'(i));
        push_frame(d, 60);
        drive(d, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("padding", dv0, 72, f0, 1, u0, 0);
    endtask

    task automatic test_crc_vector();
        logic [7:0] d[$];
        string s = "123456789";
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        sel = 1'b1;
        tick();
        for (int i = 0; i < s.len(); i++) d.push_back(s[i]);
        push_preamble();
        foreach (d[i]) expq.push_back(d[i]);
        expq.push_back(8'h26); expq.push_back(8'h39); expq.push_back(8'hF4); expq.push_back(8'hCB);
        drive(d, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("crc_vector", dv0, 21, f0, 1, u0, 0);
        sel = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1[$], f2[$];
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        int t_valid;
        for (int i = 0; i < 64; i++) begin
            f1.push_back(8'($urandom_range(0, 255)));
            f2.push_back(8'($urandom_range(0, 255)));
        end
        push_frame(f1, 60);
        first_rise = -1;
        t_valid = cyc;
        drive(f1, 1'b1);
        push_frame(f2, 60);
        drive(f2, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("back_to_back", dv0, 152, f0, 2, u0, 0);
        checks += 2;
        if (first_rise != t_valid + 1) begin
            failures++;
            $display("FAIL start_latency: TX_DV rose at cycle %0d, expected %0d", first_rise, t_valid + 1);
        end
        if (last_gap != 12) begin
            failures++;
            $display("FAIL b2b_ifg: %0d low cycles between frames, expected 12", last_gap);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] a[$], b[$];
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        for (int i = 0; i < 5; i++) a.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 14; i++) b.push_back(8'h30 + 8'(i));
        push_preamble();
        foreach (a[i]) expq.push_back(a[i]);
        drive(a, 1'b0);
        s_valid = 1'b0;
        tick();
        push_frame(b, 60);
        drive(b, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("underrun", dv0, 13 + 72, f0, 1, u0, 1);
        checks++;
        if (last_gap != 13) begin
            failures++;
            $display("FAIL underrun_ifg: %0d low cycles before next frame, expected 13", last_gap);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[$], head[$], g[$];
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        for (int i = 0; i < 40; i++) f.push_back(8'hC0 ^ 8'(i));
        for (int i = 0; i < 64; i++) g.push_back(8'($urandom_range(0, 255)));
        head = f[0:18];
        push_preamble();
        foreach (head[i]) expq.push_back(head[i]);
        drive(head, 1'b0);
        s_data  = f[19];
        s_valid = 1'b1;
        rst_n   = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        rst_n   = 1'b1;
        s_valid = 1'b0;
        repeat (3) tick();
        push_frame(g, 60);
        drive(g, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("reset_mid", dv0, 27 + 76, f0, 1, u0, 0);
    endtask

    task automatic test_short_payload();
        logic [7:0] d[$];
        int dv0 = dv_cnt, f0 = done_cnt, u0 = urun_cnt;
        d.push_back(8'hA5); d.push_back(8'hB6); d.push_back(8'hC7);
        push_frame(d, 60);
        drive(d, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        check_frame("short_payload", dv0, 72, f0, 1, u0, 0);
    endtask

    initial begin
        test_reset();
        test_padding();
        test_crc_vector();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_short_payload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
